pfb_frame_ctrl_iw36_cw11: RTL
=============================

# pfb_frame_ctrl_iw36_cw11

Frame sequencer for the `count_items_iw36_cw11` item counter in the channelizer datapath. Accepts a ready/valid sample stream and generates the counter's `valid_i`/`reset_cnt` so counts restart at every frame boundary. Checks each returned count against its own frame position and re-emits the stream with `tlast` and a count sideband. Absorbs the counter's one-item hold-back with a flush mechanism and a 4-entry output FIFO.

## Interface
Parameters:
- FIFO_DEPTH, 4: output FIFO entries. Power of two, at least 4.
- RST_LEN, 64: frame length N loaded at reset.

Ports:
- clk  in  1  clock
- sync_reset  in  1  asynchronous, active-high reset
- en_i  in  1  run enable
- cfg_len  in  11  new frame length N; values 0 and 1 are treated as 2
- cfg_load  in  1  pulse; latches cfg_len into the shadow register
- flush_i  in  1  pulse; terminates the current partial frame
- s_tvalid / s_tready  in/out  1  input handshake
- s_tdata  in  36  input sample
- cnt_valid_o  out  1  drives counter valid_i
- cnt_reset_o  out  1  drives counter reset_cnt
- cnt_data_o  out  36  drives counter data_i
- cnt_valid_i  in  1  counter valid_o
- cnt_count_i  in  11  counter count_o
- cnt_data_i  in  36  counter data_o
- m_tvalid / m_tready  out/in  1  output handshake
- m_tdata  out  36  output sample
- m_tuser  out  11  item index within the frame
- m_tlast  out  1  last item of the frame
- err_o  out  1  sticky count-mismatch flag

## Operation
- States:
  - IDLE: s_tready=0.
  - RUN: transfers input.
  - FLUSH: injects one dummy item. Lasts one cycle. s_tready=0.
- Transitions:
  - IDLE→RUN when en_i=1.
  - RUN→IDLE when en_i=0 and no real item is held.
  - RUN→FLUSH on flush_i (or timer, see Configuration) if a real item is held and FIFO free ≥2.
  - flush_i while nothing is held is ignored.
  - FLUSH→RUN when en_i=1; FLUSH→IDLE when en_i=0.
  - en_i=0 with an item held forces a FLUSH first.
- Counter interface:
  - In RUN: cnt_valid_o = s_tvalid & s_tready; cnt_data_o = s_tdata.
  - s_tready = 1 in RUN when FIFO free ≥2, using a registered occupancy count.
- Frame position pos, 0..N-1:
  - cnt_reset_o = 1 with the item at pos 0.
  - pos increments per accepted real item and wraps at N-1.
  - N updates from the shadow register only when pos wraps to 0, or on FLUSH.
- Held item: the counter emits item k only when item k+1 enters.
  - Per held item, the block keeps held_pos, held_last and held_dummy.
  - held_last = (pos==N-1).
- FLUSH:
  - Sends a dummy item: data 0, cnt_reset_o=1, held_dummy=1.
  - Forces held_last=1 on the previously held real item.
  - Resets pos to 0.
- On cnt_valid_i for a non-dummy item:
  - Writes {cnt_data_i, held_pos, held_last} into the FIFO.
  - If cnt_count_i ≠ held_pos, sets err_o. err_o clears only on reset.
- Dummy outputs are discarded, never written to the FIFO.
- Reset:
  - All outputs 0, state IDLE, FIFO empty, pos 0, N=RST_LEN, no item held.
  - Reset mid-frame discards all in-flight items.
  - The counter must share sync_reset.

## Timing
- An input accepted at cycle t and the next accept at cycle u: FIFO write at u+1, m_tvalid earliest at u+2.
- FIFO write and read may occur in the same cycle. Occupancy is unchanged in that case.
- m_tdata, m_tuser and m_tlast hold stable while m_tvalid=1 and m_tready=0.
- cfg_load coinciding with a pos wrap: the new value applies to the next frame.
- flush_i coinciding with an input accept: the accept completes first; FLUSH occurs the following cycle.

## Configuration
- PFB_FRAME_FLUSH_TIMER_EN defined:
  - A 4-bit idle counter counts RUN cycles with a real item held and no accept.
  - At 15 it triggers FLUSH as if flush_i were asserted.
- Undefined: flush only via flush_i or en_i falling.

## Test plan
- N=4, 8 continuous items (data 1..8), m_tready=1, then flush_i → outputs tuser 0,1,2,3,0,1,2,3; tlast on items 4 and 8; err_o=0.
- N=4, 6 items, then flush_i → item 6 emitted with tuser=1, tlast=1. Next input emerges with tuser=0.
- m_tready held 0 while items are streamed → s_tready drops with FIFO free <2. No item is lost or duplicated after release.
- cfg_load to N=3 at pos 2 of an N=4 frame → current frame ends at tuser 3; the next frame ends at tuser 2.
- Force cnt_count_i=5 on an item with held_pos=2 → err_o rises the cycle after and stays 1 until sync_reset.
- With PFB_FRAME_FLUSH_TIMER_EN defined, single item then idle → item emitted with tuser 0 and tlast=1 within 18 cycles.

Source files
------------

// File: rtl/pfb_frame_ctrl_iw36_cw11.sv
// Frame sequencer for count_items_iw36_cw11: drives the counter, checks returned counts, re-emits with tlast/tuser.
// Optional idle-flush timer: define PFB_FRAME_FLUSH_TIMER_EN.
`timescale 1ns/1ps
module pfb_frame_ctrl_iw36_cw11 #(
    parameter int FIFO_DEPTH = 4,
    parameter int RST_LEN    = 64
) (
    input  logic        clk,
    input  logic        sync_reset,
    input  logic        en_i,
    input  logic [10:0] cfg_len,
    input  logic        cfg_load,
    input  logic        flush_i,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [35:0] s_tdata,
    output logic        cnt_valid_o,
    output logic        cnt_reset_o,
    output logic [35:0] cnt_data_o,
    input  logic        cnt_valid_i,
    input  logic [10:0] cnt_count_i,
    input  logic [35:0] cnt_data_i,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [35:0] m_tdata,
    output logic [10:0] m_tuser,
    output logic        m_tlast,
    output logic        err_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [10:0] RST_N = (RST_LEN < 2) ? 11'd2 : 11'(RST_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [10:0] pos_q, pos_d, n_q, n_d, shadow_q, shadow_d;
    logic        held_valid_q, held_valid_d, held_last_q, held_last_d, held_dummy_q, held_dummy_d;
    logic [10:0] held_pos_q, held_pos_d;
    logic        pend_valid_q, pend_valid_d, pend_last_q, pend_last_d, pend_dummy_q, pend_dummy_d;
    logic [10:0] pend_pos_q, pend_pos_d;
    logic        flush_pend_q, flush_pend_d;
    logic [PW:0] occ_q, occ_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        err_q, err_d;
    logic [47:0] mem_q [FIFO_DEPTH];

    logic        free2, real_held, accept, is_flush, inject, at_end;
    logic        flush_req, timer_hit, wr_en, rd_en;
    logic [10:0] cfg_sat, shadow_eff;
    logic [47:0] rd_word;

    assign free2      = occ_q <= (PW+1)'(FIFO_DEPTH - 2);
    assign real_held  = held_valid_q & ~held_dummy_q;
    assign s_tready   = (state_q == ST_RUN) & free2;
    assign accept     = s_tvalid & s_tready;
    assign is_flush   = (state_q == ST_FLUSH);
    assign inject     = accept | is_flush;
    assign at_end     = (pos_q == n_q - 11'd1);
    assign cfg_sat    = (cfg_len < 11'd2) ? 11'd2 : cfg_len;
    // A load landing on the wrap cycle must already govern the frame that starts there.
    assign shadow_eff = cfg_load ? cfg_sat : shadow_q;
    assign flush_req  = flush_i | flush_pend_q | timer_hit;

    assign cnt_valid_o = inject;
    assign cnt_reset_o = is_flush | (accept & (pos_q == 11'd0));
    assign cnt_data_o  = (state_q == ST_RUN) ? s_tdata : 36'd0;

    // The counter returns the previously held item one cycle after an injection; pend tags it.
    assign wr_en    = cnt_valid_i & pend_valid_q & ~pend_dummy_q;
    assign m_tvalid = (wr_ptr_q != rd_ptr_q);
    assign rd_en    = m_tvalid & m_tready;
    assign rd_word  = mem_q[rd_ptr_q[PW-1:0]];
    assign m_tdata  = rd_word[47:12];
    assign m_tuser  = rd_word[11:1];
    assign m_tlast  = rd_word[0];
    assign err_o    = err_q;

`ifdef PFB_FRAME_FLUSH_TIMER_EN
    logic [3:0] idle_q, idle_d;

    always_comb begin
        idle_d = 4'd0;
        if (state_q == ST_RUN && real_held && !accept)
            idle_d = (idle_q == 4'hF) ? idle_q : idle_q + 4'd1;
    end

    assign timer_hit = (idle_d == 4'hF);

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) idle_q <= 4'd0;
        else            idle_q <= idle_d;
    end
`else
    assign timer_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en_i) state_d = ST_RUN;
            ST_RUN: begin
                if ((flush_req || !en_i) && (real_held || accept)) begin
                    if (free2) state_d = ST_FLUSH;
                end else if (!en_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: state_d = en_i ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        pos_d        = pos_q;
        n_d          = n_q;
        shadow_d     = cfg_load ? cfg_sat : shadow_q;
        held_valid_d = held_valid_q;
        held_pos_d   = held_pos_q;
        held_last_d  = held_last_q;
        held_dummy_d = held_dummy_q;
        pend_valid_d = inject & held_valid_q;
        pend_pos_d   = held_pos_q;
        pend_last_d  = held_last_q | is_flush;
        pend_dummy_d = held_dummy_q;
        flush_pend_d = flush_pend_q;
        if (is_flush) begin
            pos_d        = 11'd0;
            n_d          = shadow_eff;
            held_valid_d = 1'b1;
            held_pos_d   = 11'd0;
            held_last_d  = 1'b0;
            held_dummy_d = 1'b1;
        end else if (accept) begin
            held_valid_d = 1'b1;
            held_pos_d   = pos_q;
            held_last_d  = at_end;
            held_dummy_d = 1'b0;
            if (at_end) begin
                pos_d = 11'd0;
                n_d   = shadow_eff;
            end else begin
                pos_d = pos_q + 11'd1;
            end
        end
        // Remember a flush request that could not be honoured yet (FIFO too full).
        if (state_q != ST_RUN)
            flush_pend_d = 1'b0;
        else if (flush_i && (real_held || accept) && state_d != ST_FLUSH)
            flush_pend_d = 1'b1;
        // Occupancy reserves a slot when a real item is pushed out of the counter.
        occ_d    = occ_q + (PW+1)'(inject & real_held) - (PW+1)'(rd_en);
        wr_ptr_d = wr_ptr_q + (PW+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (PW+1)'(rd_en);
        err_d    = err_q | (wr_en & (cnt_count_i != pend_pos_q));
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            pos_q        <= 11'd0;
            n_q          <= RST_N;
            shadow_q     <= RST_N;
            held_valid_q <= 1'b0;
            held_pos_q   <= 11'd0;
            held_last_q  <= 1'b0;
            held_dummy_q <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pos_q   <= 11'd0;
            pend_last_q  <= 1'b0;
            pend_dummy_q <= 1'b0;
            flush_pend_q <= 1'b0;
            occ_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            n_q          <= n_d;
            shadow_q     <= shadow_d;
            held_valid_q <= held_valid_d;
            held_pos_q   <= held_pos_d;
            held_last_q  <= held_last_d;
            held_dummy_q <= held_dummy_d;
            pend_valid_q <= pend_valid_d;
            pend_pos_q   <= pend_pos_d;
            pend_last_q  <= pend_last_d;
            pend_dummy_q <= pend_dummy_d;
            flush_pend_q <= flush_pend_d;
            occ_q        <= occ_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_q        <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or posedge sync_reset) begin
                if (sync_reset)
                    mem_q[gi] <= 48'd0;
                else if (wr_en && wr_ptr_q[PW-1:0] == PW'(gi))
                    mem_q[gi] <= {cnt_data_i, pend_pos_q, pend_last_q};
            end
        end
    endgenerate

endmodule
